// File: rtl/ws2812_ram_arb.sv
// ws2812_ram_arb: shares the single-port LED RAM between one host writer and NUM_CH channel readers.
// Defining WS2812_ARB_STATS_EN adds a write/read conflict counter (stat_clr_in, conf_cnt_out).
module ws2812_ram_arb #(
  parameter int CH_BITS      = 2,
  parameter int WR_BURST_MAX = 4,
  parameter int NUM_CH       = 1 << CH_BITS,
  parameter int AW           = CH_BITS + 6
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                wr_req_in,
  input  logic [AW-1:0]       wr_addr_in,
  input  logic [31:0]         wr_data_in,
  output logic                wr_ack_out,
  input  logic [NUM_CH-1:0]   rd_req_in,
  input  logic [NUM_CH*6-1:0] rd_addr_in,
  output logic [NUM_CH-1:0]   rd_ack_out,
  output logic [31:0]         rd_data_out,
`ifdef WS2812_ARB_STATS_EN
  input  logic                stat_clr_in,
  output logic [15:0]         conf_cnt_out,
`endif
  output logic                ram_wr_en_out,
  output logic                ram_rd_en_out,
  output logic [AW-1:0]       ram_addr_out,
  output logic [31:0]         ram_wr_data_out,
  input  logic [31:0]         ram_rd_data_in
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t             state_q;
  logic [CH_BITS-1:0] ptr_q, ch_q, rr_sel, idx;
  logic [3:0]         cnt_q;
  logic               wr_q, rd_pend, wr_gnt;
  logic [5:0]         rd_idx;
  // Search from ptr+1 upward; iterating downward lets the nearest requester win.
  always_comb begin
    rr_sel = '0;
    idx    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr_q + CH_BITS'(i);
      if (rd_req_in[idx]) rr_sel = idx;
    end
    rd_idx  = rd_addr_in[6*int'(rr_sel) +: 6];
    rd_pend = |rd_req_in;
    wr_gnt  = wr_req_in && (!rd_pend || cnt_q < 4'(WR_BURST_MAX));
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q         <= IDLE;
      ptr_q           <= CH_BITS'(NUM_CH - 1);
      cnt_q           <= '0;
      ch_q            <= '0;
      wr_q            <= 1'b0;
      wr_ack_out      <= 1'b0;
      rd_ack_out      <= '0;
      rd_data_out     <= '0;
      ram_wr_en_out   <= 1'b0;
      ram_rd_en_out   <= 1'b0;
      ram_addr_out    <= '0;
      ram_wr_data_out <= '0;
    end else begin
      wr_ack_out    <= 1'b0;
      rd_ack_out    <= '0;
      ram_wr_en_out <= 1'b0;
      ram_rd_en_out <= 1'b0;
      case (state_q)
        IDLE:
          if (wr_gnt) begin
            state_q         <= ACCESS;
            wr_q            <= 1'b1;
            ram_wr_en_out   <= 1'b1;
            ram_addr_out    <= wr_addr_in;
            ram_wr_data_out <= wr_data_in;
            cnt_q           <= rd_pend ? cnt_q + 4'd1 : 4'd0;
          end else if (rd_pend) begin
            state_q       <= ACCESS;
            wr_q          <= 1'b0;
            ch_q          <= rr_sel;
            ptr_q         <= rr_sel;
            cnt_q         <= '0;
            ram_rd_en_out <= 1'b1;
            ram_addr_out  <= {rr_sel, rd_idx};
          end
        ACCESS: state_q <= DONE;
        default: begin
          state_q <= IDLE;
          if (wr_q) wr_ack_out <= 1'b1;
          else begin
            rd_ack_out  <= NUM_CH'(1) << ch_q;
            rd_data_out <= ram_rd_data_in;
          end
        end
      endcase
    end
`ifdef WS2812_ARB_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) conf_cnt_out <= '0;
    else if (stat_clr_in) conf_cnt_out <= '0;
    else if (state_q == IDLE && wr_req_in && rd_pend && conf_cnt_out != 16'hFFFF)
      conf_cnt_out <= conf_cnt_out + 16'd1;
`endif
endmodule

// File: tb/tb_ws2812_ram_arb.sv
// tb_ws2812_ram_arb: directed bench for ws2812_ram_arb with a small behavioural RAM.
module tb_ws2812_ram_arb;
  logic        clk_in = 1'b0, rst_n_in = 1'b0;
  logic        wr_req_in = 1'b0, wr_ack_out;
  logic [7:0]  wr_addr_in = '0;
  logic [31:0] wr_data_in = '0;
  logic [3:0]  rd_req_in = '0, rd_ack_out;
  logic [23:0] rd_addr_in = '0;
  logic [31:0] rd_data_out, ram_wr_data_out, ram_rd_data_in;
  logic        ram_wr_en_out, ram_rd_en_out;
  logic [7:0]  ram_addr_out;
  logic        stat_clr_in = 1'b0;
  logic [15:0] conf_cnt_out;
  logic [31:0] mem [256];
  int n_chk = 0, n_fail = 0;
  int g;

  ws2812_ram_arb dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_ack_out(wr_ack_out),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_ack_out(rd_ack_out), .rd_data_out(rd_data_out),
`ifdef WS2812_ARB_STATS_EN
    .stat_clr_in(stat_clr_in), .conf_cnt_out(conf_cnt_out),
`endif
    .ram_wr_en_out(ram_wr_en_out), .ram_rd_en_out(ram_rd_en_out), .ram_addr_out(ram_addr_out),
    .ram_wr_data_out(ram_wr_data_out), .ram_rd_data_in(ram_rd_data_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (ram_rd_en_out) ram_rd_data_in <= mem[ram_addr_out];
    if (ram_wr_en_out) mem[ram_addr_out] <= ram_wr_data_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    mem[8'h85] = 32'h0A12_3456;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_wr_ack", wr_ack_out, 0);
    check("rst_rd_ack", rd_ack_out, 0);
    check("rst_rd_data", rd_data_out, 0);
    check("rst_strobes", {ram_wr_en_out, ram_rd_en_out}, 0);
    check("rst_addr", ram_addr_out, 0);
    check("rst_wdata", ram_wr_data_out, 0);
    @(negedge clk_in) rst_n_in = 1'b1;

    // all channels held: ch0 first, strict rotation, acks 3 cycles apart
    rd_addr_in = {6'd11, 6'd10, 6'd9, 6'd8};
    rd_req_in  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      tick; check("rr_addr", ram_addr_out, 32'(g * 64 + g + 8));
      check("rr_rd_en", ram_rd_en_out, 1);
      tick; check("rr_gap", rd_ack_out, 0);
      tick; check("rr_ack", rd_ack_out, 32'(1 << g));
    end
    rd_req_in = '0;

    // single read ch2 index 5
    tick;
    rd_addr_in = 24'd5 << 12;
    rd_req_in  = 4'b0100;
    tick; check("rd_strobe", ram_rd_en_out, 1);
    check("rd_addr", ram_addr_out, 32'h85);
    check("rd_no_wr", ram_wr_en_out, 0);
    tick; check("rd_access_end", ram_rd_en_out, 0);
    check("rd_no_early_ack", rd_ack_out, 0);
    tick; check("rd_ack", rd_ack_out, 4'b0100);
    check("rd_data", rd_data_out, 32'h0A12_3456);
    rd_req_in = '0;
    tick; check("rd_ack_pulse", rd_ack_out, 0);
    check("rd_data_hold", rd_data_out, 32'h0A12_3456);
    check("rd_idle_strobe", ram_rd_en_out, 0);

    // single write
    wr_addr_in = 8'h3F;
    wr_data_in = 32'hDEAD_BEEF;
    wr_req_in  = 1'b1;
    tick; check("wr_strobe", ram_wr_en_out, 1);
    check("wr_addr", ram_addr_out, 32'h3F);
    check("wr_data", ram_wr_data_out, 32'hDEAD_BEEF);
    check("wr_no_rd", ram_rd_en_out, 0);
    wr_addr_in = 8'h00;
    tick; check("wr_strobe_len", ram_wr_en_out, 0);
    check("wr_addr_latched", ram_addr_out, 32'h3F);
    check("wr_no_early_ack", wr_ack_out, 0);
    tick; check("wr_ack", wr_ack_out, 1);
    check("wr_ack_no_rd", ram_rd_en_out, 0);
    wr_req_in = 1'b0;
    tick; check("wr_ack_pulse", wr_ack_out, 0);
    check("wr_mem", mem[8'h3F], 32'hDEAD_BEEF);

    // write burst limit: 4 writes, ch1 read, writes resume
    wr_addr_in = 8'h10;
    wr_req_in  = 1'b1;
    rd_req_in  = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick; check("burst_strobe", {ram_wr_en_out, ram_rd_en_out}, (k == 4) ? 2'b01 : 2'b10);
      tick;
      tick; check("burst_wr_ack", wr_ack_out, (k == 4) ? 0 : 1);
      check("burst_rd_ack", rd_ack_out, (k == 4) ? 4'b0010 : 4'b0000);
      if (k == 4) rd_req_in = '0;
    end
    wr_req_in = 1'b0;

    // reset during a read access
    rd_addr_in = {6'd11, 6'd10, 6'd9, 6'd8};
    rd_req_in  = 4'b0100;
    tick; check("rst_mid_strobe", ram_rd_en_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("rst_mid_rd_en", ram_rd_en_out, 0);
    check("rst_mid_addr", ram_addr_out, 0);
    check("rst_mid_rd_data", rd_data_out, 0);
    rd_req_in = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; check("rst_no_ack", rd_ack_out, 0);
    end
    rd_req_in = 4'hF;
    tick; check("rst_next_addr", ram_addr_out, 32'h08);
    tick;
    tick; check("rst_next_ch0", rd_ack_out, 4'b0001);
    rd_req_in = '0;
    tick;

`ifdef WS2812_ARB_STATS_EN
    check("stat_rst", conf_cnt_out, 0);
    wr_req_in = 1'b1;
    rd_req_in = 4'b0001;
    repeat (7) tick;
    wr_req_in = 1'b0;
    rd_req_in = '0;
    repeat (3) tick;
    check("stat_cnt", conf_cnt_out, 3);
    stat_clr_in = 1'b1;
    tick;
    stat_clr_in = 1'b0;
    check("stat_clr", conf_cnt_out, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
